// File: rtl/um2axis_tx.sv
// UM packet-out to AXI4-Stream TX store-and-forward bridge; UM2AXIS_STATS_EN adds packet counters.
// Latency: commit beat -> tvalid 3 cycles. Backpressure: tready stalls reads; pktout_ready drops when a max packet or meta entry may not fit.

module um2axis_fifo #(
   parameter int W  = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  push_dat,
   input  logic          pop,
   output logic [W-1:0]  pop_dat,
   output logic [AW:0]   cnt,
   output logic          empty
);
   logic [W-1:0] mem_q [2**AW];
   logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
   logic         full, do_push, do_pop;

   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty   = (wr_q == rd_q);
   assign cnt     = wr_q - rd_q;
   assign pop_dat = mem_q[rd_q[AW-1:0]];

   always_comb begin
      do_push = push && !full;
      do_pop  = pop && !empty;
      wr_d    = wr_q + (AW+1)'(do_push);
      rd_d    = rd_q + (AW+1)'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= push_dat;
   end
endmodule

module um2axis_tx #(
   parameter int DATA_AW       = 8,
   parameter int META_AW       = 4,
   parameter int MAX_PKT_BEATS = 48
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [255:0] pktout_data,
   input  logic [31:0]  pktout_keep,
   input  logic [127:0] pktout_tuser,
   input  logic         pktout_data_wr,
   input  logic         pktout_data_valid_wr,
   input  logic         pktout_data_valid,
   output logic         pktout_ready,
   output logic [255:0] tx_axis_tdata,
   output logic [31:0]  tx_axis_tkeep,
   output logic [127:0] tx_axis_tuser,
   output logic         tx_axis_tlast,
   output logic         tx_axis_tvalid,
   input  logic         tx_axis_tready
`ifdef UM2AXIS_STATS_EN
   ,
   output logic [31:0]  stat_tx_pkts,
   output logic [31:0]  stat_drop_pkts,
   output logic [31:0]  stat_ovf_pkts
`endif
);
   localparam int PW    = DATA_AW + 1;
   localparam int CW    = $clog2(MAX_PKT_BEATS + 1);
   localparam int DEPTH = 2**DATA_AW;
   localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_PKT_BEATS - 1);

   typedef struct packed {
      logic         last;
      logic [31:0]  keep;
      logic [255:0] data;
   } beat_t;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

   beat_t mem [DEPTH];
   beat_t ram_wdat, rd_beat_q;

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, pkt_start_q, pkt_start_d, wr_commit_q, wr_commit_d;
   logic [PW-1:0]    rd_ptr_q, rd_done_q, rd_done_d, used_d, free_d;
   logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
   logic             ovf_q, ovf_d, ready_q, ready_d;
   logic [127:0]     tuser_lat_q, tuser_lat_d, meta_wdat, meta_rdat, tuser_q;
   logic [META_AW:0] meta_cnt, meta_cnt_d;
   logic             meta_empty, meta_pop;
   logic             first_beat, eop, ram_we, commit, drop, hs, rd_en, tvalid_q;
   state_t           state_q;

   // Write side: beats land at wr_ptr; a dropped packet rewinds to its first slot.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      pkt_start_d = pkt_start_q;
      wr_commit_d = wr_commit_q;
      beat_cnt_d  = beat_cnt_q;
      ovf_d       = ovf_q;
      tuser_lat_d = tuser_lat_q;
      first_beat  = (beat_cnt_q == '0);
      eop         = pktout_data_wr && pktout_data_valid_wr;
      ram_we      = pktout_data_wr && !ovf_q;
      commit      = eop && pktout_data_valid && !ovf_q;
      drop        = eop && !commit;
      meta_wdat   = first_beat ? pktout_tuser : tuser_lat_q;
      ram_wdat    = {commit, pktout_keep, pktout_data};

      if (pktout_data_wr && first_beat) begin
         pkt_start_d = wr_ptr_q;
         tuser_lat_d = pktout_tuser;
      end
      if (ram_we) begin
         wr_ptr_d   = wr_ptr_q + PW'(1);
         beat_cnt_d = beat_cnt_q + CW'(1);
         if (beat_cnt_q == LAST_BEAT) ovf_d = 1'b1;
      end
      if (commit) begin
         wr_commit_d = wr_ptr_q + PW'(1);
         beat_cnt_d  = '0;
         ovf_d       = 1'b0;
      end else if (drop) begin
         wr_ptr_d   = first_beat ? wr_ptr_q : pkt_start_q;
         beat_cnt_d = '0;
         ovf_d      = 1'b0;
      end
   end

   // Read side handshake and space accounting against beats actually accepted by AXIS.
   always_comb begin
      hs         = tvalid_q && tx_axis_tready;
      meta_pop   = hs && rd_beat_q.last;
      rd_en      = (state_q == S_LOAD) || (hs && !rd_beat_q.last);
      rd_done_d  = rd_done_q + PW'(hs);
      meta_cnt_d = meta_cnt + (META_AW+1)'(commit) - (META_AW+1)'(meta_pop);
      used_d     = wr_ptr_d - rd_done_d;
      free_d     = PW'(DEPTH) - used_d;
      ready_d    = (free_d >= PW'(MAX_PKT_BEATS)) && (meta_cnt_d < (META_AW+1)'(2**META_AW));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         pkt_start_q <= '0;
         wr_commit_q <= '0;
         rd_done_q   <= '0;
         beat_cnt_q  <= '0;
         ovf_q       <= 1'b0;
         tuser_lat_q <= '0;
         ready_q     <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         pkt_start_q <= pkt_start_d;
         wr_commit_q <= wr_commit_d;
         rd_done_q   <= rd_done_d;
         beat_cnt_q  <= beat_cnt_d;
         ovf_q       <= ovf_d;
         tuser_lat_q <= tuser_lat_d;
         ready_q     <= ready_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) mem[wr_ptr_q[DATA_AW-1:0]] <= ram_wdat;
   end

   // The RAM output register is the AXIS data register; it only moves on LOAD or a non-last handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_beat_q <= '0;
      else if (rd_en) rd_beat_q <= mem[rd_ptr_q[DATA_AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         tvalid_q <= 1'b0;
         tuser_q  <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
         case (state_q)
            S_IDLE: if (!meta_empty && (rd_ptr_q != wr_commit_q)) state_q <= S_LOAD;
            S_LOAD: begin
               tuser_q  <= meta_rdat;
               tvalid_q <= 1'b1;
               state_q  <= S_SEND;
            end
            S_SEND: if (meta_pop) begin
               tvalid_q <= 1'b0;
               state_q  <= (meta_cnt > (META_AW+1)'(1)) ? S_LOAD : S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   um2axis_fifo #(.W(128), .AW(META_AW)) u_meta (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (commit),
      .push_dat (meta_wdat),
      .pop      (meta_pop),
      .pop_dat  (meta_rdat),
      .cnt      (meta_cnt),
      .empty    (meta_empty)
   );

   assign pktout_ready   = ready_q;
   assign tx_axis_tdata  = rd_beat_q.data;
   assign tx_axis_tkeep  = rd_beat_q.keep;
   assign tx_axis_tlast  = rd_beat_q.last;
   assign tx_axis_tuser  = tuser_q;
   assign tx_axis_tvalid = tvalid_q;

`ifdef UM2AXIS_STATS_EN
   logic [31:0] tx_pkts_q, tx_pkts_d, drop_pkts_q, drop_pkts_d, ovf_pkts_q, ovf_pkts_d;

   always_comb begin
      tx_pkts_d   = tx_pkts_q   + 32'(meta_pop && (tx_pkts_q != '1));
      drop_pkts_d = drop_pkts_q + 32'(drop && (drop_pkts_q != '1));
      ovf_pkts_d  = ovf_pkts_q  + 32'(eop && ovf_q && (ovf_pkts_q != '1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_pkts_q   <= '0;
         drop_pkts_q <= '0;
         ovf_pkts_q  <= '0;
      end else begin
         tx_pkts_q   <= tx_pkts_d;
         drop_pkts_q <= drop_pkts_d;
         ovf_pkts_q  <= ovf_pkts_d;
      end
   end

   assign stat_tx_pkts   = tx_pkts_q;
   assign stat_drop_pkts = drop_pkts_q;
   assign stat_ovf_pkts  = ovf_pkts_q;
`endif
endmodule
